// File: rtl/reg_bank_scan.sv
// Parametrised register file with N combinational read ports, one write port and a
// valid/ready dump engine. Define REG_BANK_BYPASS_EN for same-cycle write-to-read forwarding.

// One read lane: zero-register masking plus optional forwarding of the in-flight write.
module reg_bank_scan_port #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] stored,
   input  logic              wr_ok,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] data
);
`ifndef REG_BANK_BYPASS_EN
   logic unused_fwd;
   assign unused_fwd = &{1'b0, wr_ok, wr_addr, wr_data};
`endif

   always_comb begin
      data = stored;
      if (ZERO_REG != 0 && addr == '0) data = '0;
`ifdef REG_BANK_BYPASS_EN
      // wr_ok already excludes dropped writes to the zero register
      if (wr_ok && wr_addr == addr) data = wr_data;
`endif
   end
endmodule

module reg_bank_scan #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int N_RD     = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_RD*ADDR_W-1:0] rd_addr,
   output logic [N_RD*DATA_W-1:0] rd_data,
   input  logic                   we,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   dump_start,
   output logic                   dump_busy,
   output logic                   dump_valid,
   input  logic                   dump_ready,
   output logic [ADDR_W-1:0]      dump_idx,
   output logic [DATA_W-1:0]      dump_data,
   output logic                   dump_done
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   logic [DATA_W-1:0] regs [DEPTH];
   logic              wr_ok;
   state_t            state, state_nx;
   logic [ADDR_W-1:0] idx, idx_nx;

   assign wr_ok = we && !(ZERO_REG != 0 && wr_addr == '0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   for (genvar k = 0; k < N_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = rd_addr[k*ADDR_W +: ADDR_W];
      reg_bank_scan_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_port (
         .addr    (ra),
         .stored  (regs[ra]),
         .wr_ok   (wr_ok),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .data    (rd_data[k*DATA_W +: DATA_W])
      );
   end

   // Dump lane reads live contents, so a stalled beat tracks writes to its register
   reg_bank_scan_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_dump (
      .addr    (idx),
      .stored  (regs[idx]),
      .wr_ok   (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (dump_data)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      idx_nx     = idx;
      dump_valid = 1'b0;
      dump_busy  = 1'b0;
      dump_done  = 1'b0;
      case (state)
         IDLE: begin
            idx_nx = '0;
            if (dump_start) state_nx = SCAN;
         end
         SCAN: begin
            dump_valid = 1'b1;
            dump_busy  = 1'b1;
            if (dump_ready) begin
               if (idx == LAST) state_nx = DONE;
               else             idx_nx   = idx + 1'b1;
            end
         end
         DONE: begin
            dump_done = 1'b1;
            dump_busy = 1'b1;
            state_nx  = IDLE;
            idx_nx    = '0;
         end
         default: begin
            state_nx = IDLE;
            idx_nx   = '0;
         end
      endcase
   end

   assign dump_idx = idx;
endmodule

// File: tb/tb_reg_bank_scan.sv
// Directed bench for reg_bank_scan: reads/writes against a model, dump beats against a scoreboard queue.
module tb_reg_bank_scan;
   localparam int DW = 32, AW = 5, NR = 2, ZR = 1, DEPTH = 1 << AW;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*DW-1:0]  rd_data;
   logic              we;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic              dump_start, dump_busy, dump_valid, dump_ready, dump_done;
   logic [AW-1:0]     dump_idx;
   logic [DW-1:0]     dump_data;

   int                n_asrt = 0, n_fail = 0;
   logic [DW-1:0]     mdl [DEPTH];
   logic [AW+DW-1:0]  sb [$];
   logic [DW-1:0]     bexp;

   always #5 clk = ~clk;

   reg_bank_scan #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_REG(ZR)) dut (
      .clk        (clk),
      .reset      (reset),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .we         (we),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .dump_start (dump_start),
      .dump_busy  (dump_busy),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_idx   (dump_idx),
      .dump_data  (dump_data),
      .dump_done  (dump_done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input int a, input logic [DW-1:0] d);
      we = 1'b1; wr_addr = AW'(a); wr_data = d;
      tick();
      we = 1'b0;
      if (!(ZR != 0 && a == 0)) mdl[a] = d;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " valid"}, 64'(dump_valid), 64'(0));
      chk({tag, " busy"},  64'(dump_busy),  64'(0));
      chk({tag, " done"},  64'(dump_done),  64'(0));
      chk({tag, " idx"},   64'(dump_idx),   64'(0));
   endtask

   // Full dump; optional stall of stall_len cycles at stall_idx with a write of stall_wd mid-stall
   task automatic run_dump(input int stall_idx, input int stall_len, input logic [DW-1:0] stall_wd,
                           input string tag);
      int cyc = 0, beats = 0, stalls = 0;
      bit done_seen = 1'b0;
      logic [AW+DW-1:0] e;
      sb.delete();
      for (int i = 0; i < DEPTH; i++)
         sb.push_back({AW'(i), (stall_len > 0 && i == stall_idx) ? stall_wd : mdl[i]});
      dump_ready = 1'b1; dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      while (!done_seen && cyc < 4 * DEPTH) begin
         dump_ready = 1'b1;
         if (dump_valid && int'(dump_idx) == stall_idx && stalls < stall_len) begin
            dump_ready = 1'b0;
            stalls++;
            if (stalls == 2) begin
               we = 1'b1; wr_addr = AW'(stall_idx); wr_data = stall_wd;
               mdl[stall_idx] = stall_wd;
            end
         end
         if (dump_valid && stall_len > 0 && int'(dump_idx) == stall_idx + 3) dump_start = 1'b1;
         #1;
         if (dump_busy) cyc++;
         if (!dump_ready) begin
            chk({tag, " stall idx"}, 64'(dump_idx), 64'(stall_idx));
            if (stalls == 3) chk({tag, " live data"}, 64'(dump_data), 64'(stall_wd));
         end
         if (dump_valid && dump_ready) begin
            e = (sb.size() > 0) ? sb.pop_front() : 'x;
            chk({tag, " beat"}, 64'({dump_idx, dump_data}), 64'(e));
            beats++;
         end
         if (dump_done) begin
            done_seen = 1'b1;
            chk({tag, " beats"},  64'(beats), 64'(DEPTH));
            chk({tag, " cycles"}, 64'(cyc),   64'(DEPTH + 1 + stall_len));
            chk({tag, " done valid"}, 64'(dump_valid), 64'(0));
         end
         tick();
         we = 1'b0; dump_start = 1'b0;
      end
      chk({tag, " done seen"}, 64'(done_seen), 64'(1));
      chk({tag, " sb empty"}, 64'(sb.size()), 64'(0));
      chk_idle({tag, " after"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      dump_start = 1'b0; dump_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

      // Reset then read everything
      tick();
      chk_idle("in reset");
      dump_start = 1'b1; we = 1'b1; wr_addr = AW'(3); wr_data = 32'hFFFF_FFFF;
      tick();
      reset = 1'b1; dump_start = 1'b0; we = 1'b0;
      chk_idle("post reset");
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = {AW'(DEPTH - 1 - a), AW'(a)};
         #1;
         chk("reset rd0", 64'(rd_data[0 +: DW]),  64'(0));
         chk("reset rd1", 64'(rd_data[DW +: DW]), 64'(0));
      end

      // Write/read and zero register
      tick();
      do_write(5, 32'hDEAD_BEEF);
      do_write(0, 32'h1234_5678);
      rd_addr = {AW'(0), AW'(5)};
      #1;
      chk("wr x5", 64'(rd_data[0 +: DW]),  64'(mdl[5]));
      chk("wr x0", 64'(rd_data[DW +: DW]), 64'(0));

      // Same-cycle write/read
      tick();
      we = 1'b1; wr_addr = AW'(7); wr_data = 32'hA5A5_A5A5; rd_addr = {AW'(5), AW'(7)};
`ifdef REG_BANK_BYPASS_EN
      bexp = 32'hA5A5_A5A5;
`else
      bexp = 32'h0;
`endif
      #1;
      chk("bypass x7", 64'(rd_data[0 +: DW]),  64'(bexp));
      chk("bypass x5", 64'(rd_data[DW +: DW]), 64'(32'hDEAD_BEEF));
      tick();
      we = 1'b0; mdl[7] = 32'hA5A5_A5A5;
      chk("after wr x7", 64'(rd_data[0 +: DW]), 64'(32'hA5A5_A5A5));
      we = 1'b1; wr_addr = '0; wr_data = 32'hFFFF_FFFF; rd_addr = '0;
      #1;
      chk("bypass x0", 64'(rd_data[0 +: DW]), 64'(0));
      tick();
      we = 1'b0;
      chk("after wr x0", 64'(rd_data[DW +: DW]), 64'(0));

      // Full dump with ready high
      for (int i = 0; i < DEPTH; i++) do_write(i, DW'(i * 3));
      run_dump(-1, 0, '0, "dump full");

      // Backpressure at idx 4 with a live write and an ignored mid-scan start
      run_dump(4, 3, 32'd99, "dump stall");

      // Reset mid-dump
      dump_ready = 1'b1; dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      for (int i = 0; i < 2 * DEPTH && !(dump_valid && dump_idx == AW'(10)); i++) tick();
      chk("reached idx10", 64'(dump_idx), 64'(10));
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk_idle("abort");
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("abort no done", 64'(dump_done), 64'(0));
      end
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = {AW'(a), AW'(DEPTH - 1 - a)};
         #1;
         chk("abort rd0", 64'(rd_data[0 +: DW]),  64'(0));
         chk("abort rd1", 64'(rd_data[DW +: DW]), 64'(0));
      end
      tick();
      run_dump(-1, 0, '0, "dump restart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule

// File: doc/reg_bank_scan.md
Name: reg_bank_scan

Overview:
Parametrised successor to the single-cycle datapath register file. It provides a configurable width, a configurable depth, N combinational read ports, one synchronous write port and an optional hardwired-zero register. It also contains a hardware dump engine that streams every register out over a valid/ready port, one entry per accepted beat. The dump engine replaces bench-side hierarchical peeking at register contents and lets the datapath top, or a debug unit, snapshot the register state while the core runs.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W registers
N_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 is hardwired to zero and ignores writes; 0 = register 0 is an ordinary register

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk
rd_addr  in  N_RD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
rd_data  out  N_RD*DATA_W  packed read data; port k occupies bits [k*DATA_W +: DATA_W]
we  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
dump_start  in  1  request a full register dump; acted on only in IDLE
dump_busy  out  1  high while the dump engine is in SCAN or DONE
dump_valid  out  1  dump_idx and dump_data are valid
dump_ready  in  1  consumer accepts the current beat
dump_idx  out  ADDR_W  index of the register being presented
dump_data  out  DATA_W  contents of register dump_idx
dump_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (reset==0 at a rising edge):
  - all registers cleared to 0
  - FSM goes to IDLE; scan index goes to 0
  - dump_valid=0, dump_busy=0, dump_done=0, dump_idx=0
  - a reset during a scan aborts the scan with no dump_done pulse
  - reset has priority over a simultaneous write or dump_start
- Read path:
  - asynchronous: rd_data[k] = reg[rd_addr[k]] from current register contents
  - with ZERO_REG=1, reading address 0 always returns 0
- Write path:
  - at the rising edge, if we==1, reg[wr_addr] <= wr_data
  - with ZERO_REG=1 and wr_addr==0, the write is dropped
  - no write latency beyond the edge; the new value is visible to reads from the next cycle
- Dump FSM, states IDLE, SCAN, DONE:
  - IDLE: dump_valid=0, dump_busy=0. dump_start==1 moves to SCAN with idx=0, so the first beat appears the cycle after dump_start.
  - SCAN: dump_valid=1, dump_busy=1, dump_idx=idx, dump_data=reg[idx] (combinational, live contents).
  - SCAN, on dump_valid && dump_ready: if idx == 2**ADDR_W-1, go to DONE; otherwise idx <= idx+1.
  - SCAN, dump_ready==0: hold; idx is unchanged and the beat is re-presented.
  - DONE: dump_done=1, dump_valid=0, dump_busy=1 for exactly one cycle, then IDLE with idx=0.
- Dump boundary cases:
  - dump_start while in SCAN or DONE is ignored; it is not queued.
  - A write to register idx while the beat is stalled changes dump_data in the next cycle. The dump is live, not a snapshot.
  - With ZERO_REG=1, the beat for idx 0 carries 0.
  - Minimum dump length is 2**ADDR_W+1 cycles after dump_start with dump_ready held high: 2**ADDR_W beats plus the DONE cycle.
- Width rule: idx is ADDR_W bits wide. Wrap from the last index is never taken, because the transition to DONE occurs first.

Optional Feature:
Macro: REG_BANK_BYPASS_EN.
- Defined:
  - If we==1, wr_addr==rd_addr[k], and the write is not dropped under the ZERO_REG rule, then rd_data[k]=wr_data in the same cycle (write-to-read forwarding).
  - The same forwarding applies to dump_data when wr_addr==dump_idx during SCAN.
- Undefined: reads return the pre-write register value in the write cycle.

Test Plan:
- Reset then reads: hold reset=0 for 2 edges, release, read every address on both ports -> all rd_data=0, dump_valid=0, dump_busy=0.
- Write/read and zero register: write 0xDEADBEEF to x5 and 0x12345678 to x0 (ZERO_REG=1); next cycle read x5 and x0 -> 0xDEADBEEF and 0. With ZERO_REG=0 -> x0 reads 0x12345678.
- Bypass: same-cycle we=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr[0]=7 -> rd_data[0]=0xA5A5A5A5 with REG_BANK_BYPASS_EN defined, old value 0 without it.
- Full dump, ready high: preload reg[i]=i*3, pulse dump_start -> 32 beats on consecutive cycles, idx 0..31, data 0,3,...,93 (idx 0 = 0). Then dump_done for 1 cycle, then IDLE; 33 cycles in total.
- Backpressure and live data: dump_ready=0 at idx 4 for 3 cycles and write reg[4]=99 during the stall -> idx stays 4, data becomes 99, no beat lost or duplicated after ready returns. A dump_start pulse mid-scan has no effect.
- Reset mid-dump: assert reset=0 at idx 10 -> next cycle dump_valid=0, dump_busy=0, no dump_done, registers=0. A new dump_start restarts from idx 0.
